// File: rtl/psum_adder_tree.sv
// Partial-sum adder tree: PAR signed lanes reduced by a registered binary tree, then
// accumulated per packet. Define PSUM_SAT_EN to clamp out_sum to OUT_W (default: wrap).
module psum_adder_tree #(
  parameter int PAR   = 9,
  parameter int IN_W  = 32,
  parameter int ACC_W = 48,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PAR*IN_W-1:0]     in_vec,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    out_sat
);

  localparam int D  = (PAR > 1) ? $clog2(PAR) : 1;
  localparam int NW = 2 * PAR;

  logic en;
  logic [D:0] vld_p;
  logic [D:0] last_p;
  logic signed [ACC_W-1:0] tree_p [0:D][0:NW-1];
  logic signed [ACC_W-1:0] acc_p;
  logic [CNT_W-1:0] cnt_p;
  logic signed [ACC_W-1:0] sum_p;

  function automatic int nodes(input int lvl);
    return (PAR + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic [IN_W-1:0] x);
    return {{(ACC_W-IN_W){x[IN_W-1]}}, x};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

`ifdef PSUM_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_A = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_A = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Returns {clipped_flag, value}.
  function automatic logic [OUT_W:0] clip(input logic signed [ACC_W-1:0] v);
    if (v > MAX_A)      return {1'b1, MAX_A[OUT_W-1:0]};
    else if (v < MIN_A) return {1'b1, MIN_A[OUT_W-1:0]};
    else                return {1'b0, v[OUT_W-1:0]};
  endfunction
`else
  function automatic logic [OUT_W:0] clip(input logic [OUT_W-1:0] v);
    return {1'b0, v};
  endfunction
`endif

  // A held result back-pressures and freezes every stage, so no beat is ever dropped.
  assign in_ready = !(out_valid && !out_ready);
  assign en       = in_ready;
  assign sum_p    = acc_p + tree_p[D][0];

  // Stage 0: sign-extended lanes; stages 1..D: tree levels, odd operand passes through.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int j = 0; j < PAR; j++)
        tree_p[0][j] <= sext(in_vec[j*IN_W +: IN_W]);
      for (int j = PAR; j < NW; j++)
        tree_p[0][j] <= '0;
      for (int l = 1; l <= D; l++) begin
        for (int j = 0; j < PAR; j++) begin
          if (2*j + 1 < nodes(l-1))
            tree_p[l][j] <= tree_p[l-1][2*j] + tree_p[l-1][2*j+1];
          else if (2*j < nodes(l-1))
            tree_p[l][j] <= tree_p[l-1][2*j];
          else
            tree_p[l][j] <= '0;
        end
        for (int j = PAR; j < NW; j++)
          tree_p[l][j] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p  <= '0;
      last_p <= '0;
    end else if (en) begin
      vld_p  <= {vld_p[D-1:0], in_valid};
      last_p <= {last_p[D-1:0], in_last};
    end
  end

  // Accumulator / output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p     <= '0;
      cnt_p     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= vld_p[D] && last_p[D];
      if (vld_p[D]) begin
        if (last_p[D]) begin
          acc_p     <= '0;
          cnt_p     <= '0;
          out_beats <= cnt_inc(cnt_p);
`ifdef PSUM_SAT_EN
          {out_sat, out_sum} <= clip(sum_p);
`else
          {out_sat, out_sum} <= clip(sum_p[OUT_W-1:0]);
`endif
        end else begin
          acc_p <= sum_p;
          cnt_p <= cnt_inc(cnt_p);
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_adder_tree.sv
// Bench for psum_adder_tree: table of beats with spec-derived packet results, scoreboard
// queue filled on accept and drained by an output monitor, plus stall and reset sequences.
module tb_psum_adder_tree;
  localparam int PAR = 9, IN_W = 32, ACC_W = 48, OUT_W = 32, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [PAR*IN_W-1:0] in_vec = '0;
  logic in_ready, out_valid, out_sat;
  logic signed [OUT_W-1:0] out_sum;
  logic [CNT_W-1:0] out_beats;

  psum_adder_tree #(.PAR(PAR), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_beats(out_beats), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic signed [31:0] sum;
    int beats;
    bit sat;
    int acc_cyc;
    bit chk_lat;
  } exp_t;

  typedef struct {
    int gap;
    int base;
    int step;
    bit last;
    logic signed [31:0] sum;
    int beats;
    bit sat;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  bit lat_on = 1'b1;
  vec_t tv[11];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Output monitor: scoreboard pops, hold-while-stalled and back-pressure checks.
  logic signed [31:0] p_sum;
  logic [15:0] p_beats;
  bit p_sat;
  bit p_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", out_sum, p_sum);
        check("hold_beats", out_beats, p_beats);
        check("hold_sat", out_sat, p_sat);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got out_valid=1 sum=%0d, required no pending result", out_sum);
        end else begin
          e = sb.pop_front();
          check("out_sum", out_sum, e.sum);
          check("out_beats", out_beats, e.beats);
          check("out_sat", out_sat, e.sat);
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, 5);
        end
      end
    end
    p_stall <= out_valid && !out_ready;
    p_sum   <= out_sum;
    p_beats <= out_beats;
    p_sat   <= out_sat;
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input int base, input int step, input bit last,
                      input logic signed [31:0] es, input int eb, input bit esat);
    bit rdy;
    int tries;
    tries = 0;
    for (int i = 0; i < PAR; i++) in_vec[i*IN_W +: IN_W] = base + step * i;
    in_valid = 1'b1;
    in_last  = last;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!rdy && tries < 50);
    if (!rdy) begin
      checks++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance");
    end else if (last) begin
      sb.push_back('{es, eb, esat, cyc, lat_on});
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_outstanding", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required completion");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{0, 1, 0, 1'b1, 32'sd9, 1, 1'b0};
    tv[1]  = '{8, 1, 1, 1'b0, 32'sd0, 0, 1'b0};
    tv[2]  = '{0, 1, 1, 1'b0, 32'sd0, 0, 1'b0};
    tv[3]  = '{0, 1, 1, 1'b1, 32'sd135, 3, 1'b0};
    tv[4]  = '{0, 1, 1, 1'b0, 32'sd0, 0, 1'b0};
    tv[5]  = '{0, 1, 1, 1'b0, 32'sd0, 0, 1'b0};
    tv[6]  = '{0, 1, 1, 1'b1, 32'sd135, 3, 1'b0};
    tv[7]  = '{2, 0, -1, 1'b1, -32'sd36, 1, 1'b0};
`ifdef PSUM_SAT_EN
    tv[8]  = '{1, 32'h7FFFFFFF, 0, 1'b1, 32'sh7FFFFFFF, 1, 1'b1};
`else
    tv[8]  = '{1, 32'h7FFFFFFF, 0, 1'b1, 32'sh7FFFFFF7, 1, 1'b0};
`endif
    tv[9]  = '{3, 100, 10, 1'b0, 32'sd0, 0, 1'b0};
    tv[10] = '{4, -1000, 0, 1'b1, -32'sd7740, 2, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_beats", out_beats, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      idle(tv[i].gap);
      send(tv[i].base, tv[i].step, tv[i].last, tv[i].sum, tv[i].beats, tv[i].sat);
    end
    drain();

    // Consumer stalls while beats keep arriving.
    lat_on = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        send(1, 0, 1'b1, 32'sd9, 1, 1'b0);
        send(1, 1, 1'b1, 32'sd45, 1, 1'b0);
        send(2, 0, 1'b0, 32'sd0, 0, 1'b0);
        send(3, 0, 1'b1, 32'sd45, 2, 1'b0);
        send(0, -1, 1'b1, -32'sd36, 1, 1'b0);
        send(1, 0, 1'b1, 32'sd9, 1, 1'b0);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #2;
          n++;
        end
        check("stall_result_seen", out_valid, 1);
        repeat (4) begin
          @(posedge clk);
          #2;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    lat_on = 1'b1;

    // Reset in the middle of a packet discards it.
    send(1, 0, 1'b0, 32'sd0, 0, 1'b0);
    send(1, 0, 1'b0, 32'sd0, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(1, 0, 1'b1, 32'sd9, 1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/psum_adder_tree.md
PSUM_ADDER_TREE -- requirements
Module: psum_adder_tree

Interface
REQ-001 Parameter PAR, default 9: number of input lanes, legal range 2..64.
REQ-002 Parameter IN_W, default 32: signed lane width.
REQ-003 Parameter ACC_W, default 48: signed tree and accumulator width, ACC_W >= IN_W + ceil(log2(PAR)).
REQ-004 Parameter OUT_W, default 32: signed result width, OUT_W <= ACC_W.
REQ-005 Parameter CNT_W, default 16: beat-counter width.
REQ-006 Port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 Port in_valid, input, 1 bit: an input beat is present.
REQ-009 Port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 Port in_vec, input, PAR*IN_W bits: lane i occupies in_vec[i*IN_W +: IN_W], signed.
REQ-011 Port in_last, input, 1 bit: the beat closes the current partial-sum packet.
REQ-012 Port out_valid, output, 1 bit: a result is present.
REQ-013 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-014 Port out_sum, output, OUT_W bits: packet sum, signed.
REQ-015 Port out_beats, output, CNT_W bits: number of beats in the packet.
REQ-016 Port out_sat, output, 1 bit: out_sum was clipped (see REQ-031).

Function
REQ-017 A beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-018 in_ready SHALL equal !(out_valid && !out_ready), combinationally.
REQ-019 When in_ready is 0, the whole pipeline (tree, accumulator, counter, output) SHALL freeze with no state change and no beat lost.
REQ-020 Each lane SHALL be sign-extended to ACC_W before the tree.
REQ-021 The tree SHALL be binary with D = ceil(log2(PAR)) registered levels.
- At a level with an odd operand count, the unpaired operand passes through a register.
REQ-022 A per-level valid bit SHALL accompany the data, together with a delayed copy of in_last.
REQ-023 Accumulator stage, on each valid tree output:
- Non-last beat: acc <= acc + tree; cnt <= cnt + 1.
- Last beat: result <= acc + tree; out_beats <= cnt + 1; acc <= 0; cnt <= 0; out_valid <= 1.
REQ-024 Latency: for a last beat accepted at edge k, with no stall, out_valid SHALL rise after edge k+D+1 (5 cycles for PAR=9).
REQ-025 Overflow: the accumulator SHALL wrap modulo 2^ACC_W; cnt SHALL saturate at 2^CNT_W-1.
REQ-026 out_valid, out_sum, out_beats and out_sat SHALL hold stable while out_valid && !out_ready.
REQ-027 Simultaneous events: when out_valid && out_ready coincide with a new result arriving, the output registers SHALL load the new result and out_valid SHALL stay 1.
REQ-028 Throughput: with out_ready held 1, the block SHALL accept one beat per cycle indefinitely, including back-to-back single-beat packets.
REQ-029 Beats with in_valid=0 SHALL leave the accumulator untouched, so a packet may have gaps.

Reset
REQ-030 While rst_n=0 at a rising edge, the following SHALL clear to 0: all pipeline valids, delayed last flags, acc, cnt, out_valid, out_sum, out_beats and out_sat. Reset mid-packet SHALL discard the partial packet; in_ready is 1 in the first cycle after reset.

Configuration
REQ-031 Macro PSUM_SAT_EN.
- Defined: out_sum = acc clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat = 1 when clamping occurred.
- Undefined: out_sum = low OUT_W bits of acc; out_sat is tied to 0.

Verification (PAR=9, IN_W=32, ACC_W=48, OUT_W=32)
REQ-032 Single beat, all lanes 1, in_last=1, out_ready=1 -> out_sum=9, out_beats=1, out_valid high exactly one cycle, 5 cycles after accept.
REQ-033 Three consecutive beats with lanes 1..9, last on the third -> out_sum=135, out_beats=3; a second identical packet back-to-back -> 135 again, no bubble.
REQ-034 Single beat with lane i = -i, last -> out_sum=-36, out_sat=0.
REQ-035 Result pending with out_ready=0 for 4 cycles while in_valid=1 -> out_sum held, in_ready=0, no acc change; on release, all subsequent packet sums are correct.
REQ-036 All lanes 0x7FFFFFFF, one last beat:
- PSUM_SAT_EN defined -> out_sum=0x7FFFFFFF, out_sat=1.
- PSUM_SAT_EN undefined -> out_sum=0x7FFFFFF7, out_sat=0.
REQ-037 Two non-last beats of all 1s, then rst_n=0 for 1 cycle, then one last beat of all 1s -> out_sum=9, out_beats=1.
